signal_conflict_monitor: RTL and testbench
==========================================

// Module: signal_conflict_monitor
// PURPOSE
//  Sits directly downstream of traffic_controller, between its six 3-bit light codes and the lamp drivers.
//  - Normal operation: registers the codes and passes them through to the lamp outputs.
//  - Faults detected: conflicting movements active together, illegal light codes, or a stalled controller (codes frozen).
//  - On a confirmed fault: latches a fault code and forces every lamp to flashing yellow until reset or fault_clr.
// PARAMETERS
//  PERSIST_CYCLES     4            consecutive bad samples before a conflict/invalid fault is confirmed (>=1)
//  WDOG_CYCLES        150_000_000  cycles of unchanged input before a stall fault (must exceed longest sub-state, 100M)
//  FLASH_HALF_CYCLES  25_000_000   half-period of flashing yellow (0.5 s at 50 MHz)
// PORTS
//  clk          in   1  system clock, 50 MHz
//  rst          in   1  asynchronous, active-high reset
//  fault_clr    in   1  synchronous, 1-cycle pulse; returns FAULT -> MONITOR
//  in_w_to_e    in   3  controller code, West->East
//  in_w_to_n    in   3  controller code, West->North
//  in_e_to_w    in   3  controller code, East->West
//  in_e_to_n    in   3  controller code, East->North
//  in_n_to_e    in   3  controller code, North->East
//  in_n_to_w    in   3  controller code, North->West
//  lamp_w_to_e, lamp_w_to_n, lamp_e_to_w, lamp_e_to_n, lamp_n_to_e, lamp_n_to_w   out  3 each  lamp drive {R,Y,G}
//  fault        out  1  1 while in FAULT
//  fault_code   out  2  00 none, 01 conflict, 10 invalid code, 11 watchdog stall
// BEHAVIOUR
//  Codes: RED=100, YELLOW=010, GREEN=001, RED_YELLOW=110. Any other value is invalid.
//  Reset: r_* input regs and all lamp outputs = 100; fault=0; fault_code=00; state=MONITOR; all counters 0; flash_on=1.
//  Input stage: every cycle, r_* <= in_*. Conflict and invalid checks are evaluated on r_*.
//  "Active" movement: code is GREEN, YELLOW or RED_YELLOW.
//  Conflict: both members of any of these pairs are active:
//   - WE-NE, EW-WN, EW-NE, EW-NW, WN-NE, WN-EN.
//   - All other pairs are permitted (phases {WE,EW,EN}, {WE,WN,NW}, {NE,NW,EN}).
//  State MONITOR:
//   - Lamp outputs <= r_*, i.e. 2 cycles from in_* to lamp_*.
//   - bad = conflict | invalid.
//   - If bad: persist_cnt increments; else persist_cnt clears to 0.
//   - If bad and persist_cnt == PERSIST_CYCLES-1: go to FAULT.
//   - Watchdog: if {in_*} == {r_*}, wd_cnt increments; else wd_cnt clears to 0.
//   - If wd_cnt == WDOG_CYCLES-1 with no change: go to FAULT with code 11.
//   - Simultaneous causes: priority conflict(01) > invalid(10) > watchdog(11).
//   - On entry to FAULT: fault_code latched; fault=1; flash_cnt=0; flash_on=1.
//  State FAULT:
//   - Input checks are ignored; fault_code is held.
//   - flash_cnt counts 0..FLASH_HALF_CYCLES-1, then wraps to 0 and toggles flash_on.
//   - All lamps = 010 when flash_on=1, 000 when flash_on=0. First FLASH_HALF_CYCLES cycles are yellow.
//   - Lamp outputs switch to flash on the cycle after fault rises.
//  fault_clr:
//   - In FAULT: go to MONITOR; fault=0; fault_code=00; persist_cnt=wd_cnt=0; lamps resume r_* next cycle.
//   - If the cause persists, it is re-detected after PERSIST_CYCLES.
//   - In MONITOR: fault_clr only clears persist_cnt and wd_cnt.
//  rst mid-FAULT: returns immediately to the reset values above. A fault is never cleared by the inputs alone.
//  Counter widths: 28 bits, sufficient for all defaults; parameters beyond 2^28 are unsupported.
// TESTING  (PERSIST_CYCLES=4, WDOG_CYCLES=20, FLASH_HALF_CYCLES=3)
//  1. Legal sequence (WE=EW=EN 110->001->010->100, others 100, changing every 5 cycles) -> lamps equal inputs delayed 2 cycles; fault stays 0.
//  2. WE=001 and NE=001 held 4 cycles -> fault=1, code=01, all lamps 010 x3, 000 x3, repeating.
//     Same pair held only 3 cycles -> no fault.
//  3. in_n_to_w=011 held 4 cycles -> code=10. Conflict and invalid presented together -> code=01.
//  4. All inputs frozen at 100 -> fault=1, code=11 after 20 cycles; a single-bit input change at cycle 19 -> no fault.
//  5. In FAULT, pulse fault_clr with legal inputs -> fault=0, code=00, lamps track inputs again.
//     Pulse fault_clr while conflict persists -> re-fault after 4 cycles.
//  6. Assert rst mid-flash -> lamps=100, fault=0, code=00 immediately (asynchronous); normal monitoring after release.

Source files
------------

// File: rtl/signal_conflict_monitor_if.sv
// Bundle between traffic_controller codes, the conflict monitor and the lamp drivers.
// The master side drives the light codes and the fault clear pulse; the slave side drives the lamps and fault status.
interface signal_conflict_monitor_if;
   logic       fault_clr;
   logic [2:0] in_w_to_e, in_w_to_n, in_e_to_w, in_e_to_n, in_n_to_e, in_n_to_w;
   logic [2:0] lamp_w_to_e, lamp_w_to_n, lamp_e_to_w, lamp_e_to_n, lamp_n_to_e, lamp_n_to_w;
   logic       fault;
   logic [1:0] fault_code;

   modport master (
      output fault_clr,
      output in_w_to_e, in_w_to_n, in_e_to_w, in_e_to_n, in_n_to_e, in_n_to_w,
      input  lamp_w_to_e, lamp_w_to_n, lamp_e_to_w, lamp_e_to_n, lamp_n_to_e, lamp_n_to_w,
      input  fault, fault_code
   );

   modport slave (
      input  fault_clr,
      input  in_w_to_e, in_w_to_n, in_e_to_w, in_e_to_n, in_n_to_e, in_n_to_w,
      output lamp_w_to_e, lamp_w_to_n, lamp_e_to_w, lamp_e_to_n, lamp_n_to_e, lamp_n_to_w,
      output fault, fault_code
   );
endinterface

// File: rtl/signal_conflict_monitor.sv
// Safety monitor between traffic_controller and lamp drivers: passes codes through, and on a
// confirmed conflict/invalid/stall fault latches a code and flashes every lamp yellow until cleared.
module signal_conflict_monitor #(
   parameter int PERSIST_CYCLES    = 4,
   parameter int WDOG_CYCLES       = 150_000_000,
   parameter int FLASH_HALF_CYCLES = 25_000_000
) (
   input logic                   clk,
   input logic                   rst,
   signal_conflict_monitor_if.slave bus
);
   localparam int NUM_LANES = 6;
   localparam int VEC_W     = 3;
   localparam logic [VEC_W-1:0] RED = 3'b100, YELLOW = 3'b010, GREEN = 3'b001, RED_YELLOW = 3'b110;
   localparam logic [27:0] PERSIST_LAST = 28'(PERSIST_CYCLES - 1);
   localparam logic [27:0] WDOG_LAST    = 28'(WDOG_CYCLES - 1);
   localparam logic [27:0] FLASH_LAST   = 28'(FLASH_HALF_CYCLES - 1);

   typedef enum logic {MONITOR, FAULT} state_t;

   // Lane order: 0 WE, 1 WN, 2 EW, 3 EN, 4 NE, 5 NW
   logic [NUM_LANES-1:0][VEC_W-1:0] in_v, r_q, lamp_q, lamp_d;
   logic [NUM_LANES-1:0]            active, valid;
   logic                            conflict, invalid, bad, same;
   logic                            bad_hit, wd_hit;

   state_t      state_q, state_d;
   logic [1:0]  code_q, code_d;
   logic [27:0] persist_q, persist_d, wd_q, wd_d, flash_cnt_q, flash_cnt_d;
   logic        flash_on_q, flash_on_d;

   assign in_v = {bus.in_n_to_w, bus.in_n_to_e, bus.in_e_to_n,
                  bus.in_e_to_w, bus.in_w_to_n, bus.in_w_to_e};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign active[i] = (r_q[i] == GREEN) || (r_q[i] == YELLOW) || (r_q[i] == RED_YELLOW);
      assign valid[i]  = active[i] || (r_q[i] == RED);
   end

   // Forbidden pairs: WE-NE, EW-WN, EW-NE, EW-NW, WN-NE, WN-EN
   assign conflict = (active[0] & active[4]) | (active[2] & active[1]) |
                     (active[2] & active[4]) | (active[2] & active[5]) |
                     (active[1] & active[4]) | (active[1] & active[3]);
   assign invalid  = ~&valid;
   assign bad      = conflict | invalid;
   assign same     = (in_v == r_q);
   assign bad_hit  = bad && (persist_q == PERSIST_LAST);
   assign wd_hit   = same && (wd_q == WDOG_LAST);

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      persist_d   = persist_q;
      wd_d        = wd_q;
      flash_cnt_d = flash_cnt_q;
      flash_on_d  = flash_on_q;
      case (state_q)
         MONITOR: begin
            persist_d = bad  ? persist_q + 28'd1 : 28'd0;
            wd_d      = same ? wd_q + 28'd1      : 28'd0;
            if (bus.fault_clr) begin
               persist_d = '0;
               wd_d      = '0;
            end else if (bad_hit || wd_hit) begin
               state_d     = FAULT;
               persist_d   = '0;
               wd_d        = '0;
               flash_cnt_d = '0;
               flash_on_d  = 1'b1;
               if (bad_hit) code_d = conflict ? 2'b01 : 2'b10;
               else         code_d = 2'b11;
            end
         end
         FAULT: begin
            if (bus.fault_clr) begin
               state_d   = MONITOR;
               code_d    = 2'b00;
               persist_d = '0;
               wd_d      = '0;
            end else if (flash_cnt_q == FLASH_LAST) begin
               flash_cnt_d = '0;
               flash_on_d  = ~flash_on_q;
            end else begin
               flash_cnt_d = flash_cnt_q + 28'd1;
            end
         end
         default: state_d = MONITOR;
      endcase
   end

   // Lamps follow the current state, so the flash starts one cycle after fault rises
   always_comb begin
      lamp_d = r_q;
      if (state_q == FAULT) lamp_d = {NUM_LANES{flash_on_q ? YELLOW : 3'b000}};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q         <= {NUM_LANES{RED}};
         lamp_q      <= {NUM_LANES{RED}};
         state_q     <= MONITOR;
         code_q      <= 2'b00;
         persist_q   <= '0;
         wd_q        <= '0;
         flash_cnt_q <= '0;
         flash_on_q  <= 1'b1;
      end else begin
         r_q         <= in_v;
         lamp_q      <= lamp_d;
         state_q     <= state_d;
         code_q      <= code_d;
         persist_q   <= persist_d;
         wd_q        <= wd_d;
         flash_cnt_q <= flash_cnt_d;
         flash_on_q  <= flash_on_d;
      end
   end

   assign bus.lamp_w_to_e = lamp_q[0];
   assign bus.lamp_w_to_n = lamp_q[1];
   assign bus.lamp_e_to_w = lamp_q[2];
   assign bus.lamp_e_to_n = lamp_q[3];
   assign bus.lamp_n_to_e = lamp_q[4];
   assign bus.lamp_n_to_w = lamp_q[5];
   assign bus.fault       = (state_q == FAULT);
   assign bus.fault_code  = code_q;
endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Randomized plus directed bench for signal_conflict_monitor against a cycle-count reference model.
module tb_signal_conflict_monitor;
   localparam int P = 4, W = 20, H = 3;
   typedef logic [5:0][2:0] vec_t;
   localparam vec_t ALL_RED = {6{3'b100}};

   logic clk = 1'b0;
   logic rst;
   logic clr;
   vec_t cur;
   int   n_chk = 0, n_err = 0;

   signal_conflict_monitor_if bus();

   assign bus.fault_clr = clr;
   assign bus.in_w_to_e = cur[0];
   assign bus.in_w_to_n = cur[1];
   assign bus.in_e_to_w = cur[2];
   assign bus.in_e_to_n = cur[3];
   assign bus.in_n_to_e = cur[4];
   assign bus.in_n_to_w = cur[5];

   signal_conflict_monitor #(.PERSIST_CYCLES(P), .WDOG_CYCLES(W), .FLASH_HALF_CYCLES(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: counts consecutive bad samples, unchanged cycles and cycles spent flashing
   int   pa[6] = '{0, 2, 2, 2, 1, 1};
   int   pb[6] = '{4, 1, 4, 5, 4, 3};
   vec_t m_r, m_lamp;
   bit   m_fault;
   logic [1:0] m_code;
   int   m_persist, m_wd, m_age;

   function automatic bit is_active(logic [2:0] c);
      return c == 3'b001 || c == 3'b010 || c == 3'b110;
   endfunction

   function automatic bit has_conflict(vec_t v);
      for (int k = 0; k < 6; k++)
         if (is_active(v[pa[k]]) && is_active(v[pb[k]])) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit has_invalid(vec_t v);
      for (int k = 0; k < 6; k++)
         if (!is_active(v[k]) && v[k] != 3'b100) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_r <= ALL_RED; m_lamp <= ALL_RED; m_fault <= 1'b0; m_code <= 2'b00;
         m_persist <= 0; m_wd <= 0; m_age <= 0;
      end else begin
         vec_t nl;
         bit nf, cf, bd;
         logic [1:0] nc;
         int np, nw, na;
         nf = m_fault; nc = m_code; np = m_persist; nw = m_wd; na = m_age;
         nl = m_fault ? {6{((m_age / H) % 2 == 0) ? 3'b010 : 3'b000}} : m_r;
         if (m_fault) begin
            na = m_age + 1;
            if (clr) begin nf = 1'b0; nc = 2'b00; np = 0; nw = 0; end
         end else if (clr) begin
            np = 0; nw = 0;
         end else begin
            cf = has_conflict(m_r);
            bd = cf || has_invalid(m_r);
            np = bd ? m_persist + 1 : 0;
            nw = (cur == m_r) ? m_wd + 1 : 0;
            if (np == P)      begin nf = 1'b1; nc = cf ? 2'b01 : 2'b10; end
            else if (nw == W) begin nf = 1'b1; nc = 2'b11; end
            if (nf) begin na = 0; np = 0; nw = 0; end
         end
         m_fault <= nf; m_code <= nc; m_persist <= np; m_wd <= nw; m_age <= na;
         m_lamp <= nl; m_r <= cur;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic vec_t lamps();
      return {bus.lamp_n_to_w, bus.lamp_n_to_e, bus.lamp_e_to_n,
              bus.lamp_e_to_w, bus.lamp_w_to_n, bus.lamp_w_to_e};
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("lamps", 32'(lamps()), 32'(m_lamp));
         chk("fault", 32'(bus.fault), 32'(m_fault));
         chk("code", 32'(bus.fault_code), 32'(m_code));
      end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
   endtask

   function automatic vec_t legal_vec();
      vec_t v;
      logic [2:0] codes[4] = '{3'b110, 3'b001, 3'b010, 3'b100};
      int ph[3][3] = '{'{0, 2, 3}, '{0, 1, 5}, '{4, 5, 3}};
      int p;
      v = ALL_RED;
      p = $urandom_range(2);
      for (int k = 0; k < 3; k++) v[ph[p][k]] = codes[$urandom_range(3)];
      return v;
   endfunction

   initial begin
      logic [2:0] seq[4] = '{3'b110, 3'b001, 3'b010, 3'b100};
      logic [2:0] bad_codes[4] = '{3'b000, 3'b011, 3'b101, 3'b111};
      rst = 1'b1; clr = 1'b0; cur = ALL_RED;
      #12;
      chk("rst_lamps", 32'(lamps()), 32'(ALL_RED));
      chk("rst_fault", 32'(bus.fault), 32'd0);
      chk("rst_code", 32'(bus.fault_code), 32'd0);
      @(negedge clk); rst = 1'b0;

      // Frozen at all-red: watchdog fires after W unchanged cycles
      cyc(W - 1);
      chk("wd_pre", 32'(bus.fault), 32'd0);
      cyc(1);
      chk("wd_fault", 32'(bus.fault), 32'd1);
      chk("wd_code", 32'(bus.fault_code), 32'd3);
      pulse_clr();
      chk("clr_fault", 32'(bus.fault), 32'd0);
      chk("clr_code", 32'(bus.fault_code), 32'd0);

      // Single-bit change at cycle 19 restarts the watchdog
      cyc(W - 2);
      cur[0] = 3'b000; cyc(1); cur[0] = 3'b100;
      cyc(2);
      chk("wd_change", 32'(bus.fault), 32'd0);
      pulse_clr();

      // Legal WE/EW/EN sequence
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < 4; s++) begin
            cur = ALL_RED; cur[0] = seq[s]; cur[2] = seq[s]; cur[3] = seq[s];
            cyc(5);
         end
      chk("legal_fault", 32'(bus.fault), 32'd0);

      // Conflict WE+NE: 3 cycles is tolerated, 4 confirms
      cur = ALL_RED; cur[0] = 3'b001; cur[4] = 3'b001; cyc(3);
      cur = ALL_RED; cyc(5);
      chk("conf3_fault", 32'(bus.fault), 32'd0);
      cur[0] = 3'b001; cur[4] = 3'b001; cyc(4);
      chk("conf4_pre", 32'(bus.fault), 32'd0);
      cyc(1);
      chk("conf_fault", 32'(bus.fault), 32'd1);
      chk("conf_code", 32'(bus.fault_code), 32'd1);
      cur = ALL_RED; cyc(1);
      chk("flash_y", 32'(lamps()), 32'({6{3'b010}}));
      cyc(3);
      chk("flash_off", 32'(lamps()), 32'd0);
      cyc(6);

      // Clear while conflict persists re-faults after P cycles
      cur[0] = 3'b001; cur[4] = 3'b001;
      pulse_clr();
      cyc(P - 1);
      chk("refault_pre", 32'(bus.fault), 32'd0);
      cyc(1);
      chk("refault", 32'(bus.fault), 32'd1);

      // Invalid alone -> 10; invalid with conflict -> 01
      cur = ALL_RED; cur[5] = 3'b011; pulse_clr();
      cyc(P + 1);
      chk("inv_code", 32'(bus.fault_code), 32'd2);
      cur[0] = 3'b001; cur[4] = 3'b010; pulse_clr();
      cyc(P + 1);
      chk("both_code", 32'(bus.fault_code), 32'd1);

      // Async reset mid-flash
      cyc(2);
      #2 rst = 1'b1;
      #1;
      chk("arst_lamps", 32'(lamps()), 32'(ALL_RED));
      chk("arst_fault", 32'(bus.fault), 32'd0);
      chk("arst_code", 32'(bus.fault_code), 32'd0);
      cur = ALL_RED;
      @(negedge clk); rst = 1'b0;
      cur[0] = 3'b001; cyc(3);

      // Randomized mix against the model
      for (int seg = 0; seg < 150; seg++) begin
         int kind, hold, a, b;
         kind = $urandom_range(9);
         if (m_fault && $urandom_range(1) == 1) pulse_clr();
         cur = legal_vec();
         hold = $urandom_range(8, 1);
         if (kind == 7) begin
            a = $urandom_range(5);
            cur[pa[a]] = 3'b001; cur[pb[a]] = 3'b010;
            hold = $urandom_range(6, 1);
         end else if (kind == 8) begin
            cur[$urandom_range(5)] = bad_codes[$urandom_range(3)];
            hold = $urandom_range(6, 1);
         end else if (kind == 9) begin
            hold = $urandom_range(25, 15);
         end
         b = $urandom_range(3);
         if (b == 0 && hold > 1) begin pulse_clr(); hold--; end
         cyc(hold);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
